jtpopeye_vbdma: RTL and testbench

Parametrised vertical-blank DMA engine. It is the successor to the fixed object-list DMA in the Popeye video path.
- On each VB rising edge it requests the CPU bus and streams LEN bytes from CPU RAM.
- It packs the bytes into WORDB-byte words and writes them to the object/line buffer.
- It sits between main memory (CPU bus arbitration) and the object engine.
- It adds three things the fixed block lacks: configurable length and packing, mid-transfer bus-loss pause/resume, and VB-abort.

---
 rtl/jtpopeye_vbdma.sv | 167 ++++++++++++++++
 tb/tb_jtpopeye_vbdma.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpopeye_vbdma.sv
// rtl/jtpopeye_vbdma.sv - vertical-blank DMA packing CPU RAM bytes into object buffer words
// Optional feature macro: VBDMA_DOUBLE_EN (double-buffered destination, bank bit as dst_addr MSB)
module jtpopeye_vbdma #(
  parameter int AW    = 10,
  parameter int LEN   = 768,
  parameter int WORDB = 4,
  parameter int DAW   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cen,
  input  logic               VB,
  input  logic               enable,
  output logic               busrq_n,
  input  logic               busak_n,
  output logic [AW-1:0]      src_addr,
  output logic               src_cs,
  input  logic [7:0]         src_din,
`ifdef VBDMA_DOUBLE_EN
  output logic [DAW:0]       dst_addr,
`else
  output logic [DAW-1:0]     dst_addr,
`endif
  output logic [8*WORDB-1:0] dst_data,
  output logic               dst_we,
  output logic               dst_bank,
  output logic               busy,
  output logic               done
);
  // byte counter needs one extra bit so LEN = 2^AW still fits
  localparam int BCW = AW + 1;
  localparam int LW  = (WORDB > 1) ? $clog2(WORDB) : 1;

  typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

  state_t             state, state_nx;
  logic               vb_l;
  logic [BCW-1:0]     byte_cnt;
  logic [BCW-1:0]     fetch_cnt;
  logic [LW-1:0]      lane;
  logic [8*WORDB-1:0] wbuf;
  logic [8*WORDB-1:0] word_nx;
  logic [DAW-1:0]     word_cnt;
  logic               complete;
  logic               cap;
  logic               last_cap;
  logic               abort;

  assign busrq_n = !(state == REQ || state == XFER);
  assign busy    = (state != IDLE);

  // State register, advances only on pixel-rate enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= IDLE;
    else if (cen) state <= state_nx;
  end

  // Next state plus capture/abort decode; a byte arrives when the previous fetch was granted
  always_comb begin
    state_nx  = state;
    cap       = src_cs && !busak_n;
    last_cap  = cap && (byte_cnt == BCW'(LEN - 1));
    abort     = (state == XFER) && !VB && !last_cap;
    fetch_cnt = cap ? byte_cnt + BCW'(1) : byte_cnt;
    case (state)
      IDLE: if (VB && !vb_l && enable) state_nx = REQ;
      REQ:  if (!VB) state_nx = REL;
            else if (!busak_n) state_nx = XFER;
      XFER: if (!VB || last_cap) state_nx = REL;
      REL:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Merge the incoming byte into its lane of the word under construction
  always_comb begin
    word_nx = wbuf;
    for (int i = 0; i < WORDB; i++) begin
      if (lane == LW'(i)) word_nx[8*i +: 8] = src_din;
    end
  end

  // Fetch pipeline, byte packing, word writes, completion and bank flip
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vb_l     <= 1'b0;
      src_addr <= '0;
      src_cs   <= 1'b0;
      byte_cnt <= '0;
      lane     <= '0;
      wbuf     <= '0;
      word_cnt <= '0;
      dst_addr <= '0;
      dst_data <= '0;
      dst_we   <= 1'b0;
      dst_bank <= 1'b0;
      done     <= 1'b0;
      complete <= 1'b0;
    end else begin
      dst_we <= 1'b0;
      done   <= 1'b0;
      if (cen) begin
        vb_l <= VB;
        case (state)
          REQ: begin
            if (state_nx == XFER) begin
              src_addr <= '0;
              src_cs   <= 1'b0;
              byte_cnt <= '0;
              lane     <= '0;
              wbuf     <= '0;
              word_cnt <= '0;
              complete <= 1'b0;
            end
          end
          XFER: begin
            if (abort) begin
              // partial word is dropped; bank stays on the last complete list
              src_cs <= 1'b0;
              lane   <= '0;
              wbuf   <= '0;
            end else if (busak_n) begin
              // bus lost: in-flight byte is not taken, its address is reissued later
              src_cs <= 1'b0;
            end else begin
              if (cap) begin
                byte_cnt <= byte_cnt + BCW'(1);
                if (lane == LW'(WORDB - 1) || last_cap) begin
                  dst_we   <= 1'b1;
                  dst_data <= word_nx;
`ifdef VBDMA_DOUBLE_EN
                  dst_addr <= {~dst_bank, word_cnt};
`else
                  dst_addr <= word_cnt;
`endif
                  word_cnt <= word_cnt + DAW'(1);
                  lane     <= '0;
                  wbuf     <= '0;
                end else begin
                  lane <= lane + LW'(1);
                  wbuf <= word_nx;
                end
              end
              if (last_cap) begin
                src_cs   <= 1'b0;
                complete <= 1'b1;
              end else begin
                src_cs   <= 1'b1;
                src_addr <= fetch_cnt[AW-1:0];
              end
            end
          end
          REL: begin
            if (complete) begin
              done <= 1'b1;
`ifdef VBDMA_DOUBLE_EN
              dst_bank <= ~dst_bank;
`endif
            end
            complete <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_jtpopeye_vbdma.sv
// tb/tb_jtpopeye_vbdma.sv - randomized self-checking bench for jtpopeye_vbdma
module tb_jtpopeye_vbdma;
  localparam int AW = 10, LEN = 768, WORDB = 4, DAW = 8;
`ifdef VBDMA_DOUBLE_EN
  localparam int DAO = DAW + 1;
`else
  localparam int DAO = DAW;
`endif

  logic clk = 0, rst_n = 0, cen = 0, VB = 0, enable = 0, busak_n = 1, busak_s = 1;
  logic [7:0] src_din = 0, s_din = 0;
  logic busrq_n, src_cs, dst_we, dst_bank, busy, done;
  logic [AW-1:0] src_addr;
  logic [DAO-1:0] dst_addr;
  logic [31:0] dst_data;
  logic s_busrq_n, s_src_cs, s_dst_we, s_dst_bank, s_busy, s_done;
  logic [AW-1:0] s_src_addr;
  logic [DAO-1:0] s_dst_addr;
  logic [31:0] s_dst_data;

  jtpopeye_vbdma #(.AW(AW), .LEN(LEN), .WORDB(WORDB), .DAW(DAW)) u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .VB(VB), .enable(enable),
    .busrq_n(busrq_n), .busak_n(busak_n), .src_addr(src_addr), .src_cs(src_cs),
    .src_din(src_din), .dst_addr(dst_addr), .dst_data(dst_data), .dst_we(dst_we),
    .dst_bank(dst_bank), .busy(busy), .done(done));

  jtpopeye_vbdma #(.AW(AW), .LEN(6), .WORDB(4), .DAW(DAW)) u_small (
    .clk(clk), .rst_n(rst_n), .cen(cen), .VB(VB), .enable(enable),
    .busrq_n(s_busrq_n), .busak_n(busak_s), .src_addr(s_src_addr), .src_cs(s_src_cs),
    .src_din(s_din), .dst_addr(s_dst_addr), .dst_data(s_dst_data), .dst_we(s_dst_we),
    .dst_bank(s_dst_bank), .busy(s_busy), .done(s_done));

  always #5 clk = ~clk;

  logic [7:0] ram [0:1023];
  int vectors = 0, errors = 0;

  // reference model of one frame's transfer
  typedef enum {M_IDLE, M_REQ, M_XFER, M_REL} phase_t;
  phase_t m_phase = M_IDLE;
  int m_got = 0, m_wc = 0;
  bit m_infl = 0, m_full = 0, m_bank = 0, m_vbp = 0;
  logic [7:0] m_bytes[$];
  bit e_we = 0, e_done = 0, e_wbank = 0;
  int e_addr = 0;
  logic [31:0] e_data = 0;

  // stimulus knobs and frame bookkeeping
  bit vb_drv = 0, en_drv = 0, pcen = 0;
  int gdelay = 2, rq_cens = 0, s_rq = 0, pause_at = 9999, pause_len = 0, paused = 0, abort_at = 9999;
  int f_writes, f_dones, f_rq, f_busy, f_a10;
  bit w25;
  logic [31:0] w0, w191;
  logic [39:0] s_log[$];
  int s_dones = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE; m_got = 0; m_wc = 0; m_infl = 0; m_full = 0; m_bank = 0; m_vbp = 0;
    m_bytes.delete(); e_we = 0; e_done = 0; rq_cens = 0; s_rq = 0;
  endtask

  // one enabled clock of the transfer as the behaviour is described
  task automatic model_cen();
    bit last;
    e_we = 0; e_done = 0;
    case (m_phase)
      M_IDLE: if (VB && !m_vbp && enable) m_phase = M_REQ;
      M_REQ: begin
        if (!VB) m_phase = M_REL;
        else if (!busak_n) begin
          m_phase = M_XFER; m_got = 0; m_infl = 0; m_wc = 0; m_full = 0; m_bytes.delete();
        end
      end
      M_XFER: begin
        last = m_infl && !busak_n && (m_got == LEN - 1);
        if (!VB && !last) begin
          m_phase = M_REL; m_infl = 0; m_bytes.delete();
        end else if (busak_n) begin
          m_infl = 0;
        end else begin
          if (m_infl) begin
            m_bytes.push_back(ram[m_got]);
            m_got++;
            if (m_bytes.size() == WORDB || m_got == LEN) begin
              e_we = 1; e_addr = m_wc; e_wbank = ~m_bank; e_data = 0;
              foreach (m_bytes[i]) e_data = e_data | (32'(m_bytes[i]) << (8 * i));
              m_wc++;
              m_bytes.delete();
            end
          end
          if (m_got == LEN) begin m_phase = M_REL; m_infl = 0; m_full = 1; end
          else m_infl = 1;
        end
      end
      M_REL: begin
        m_phase = M_IDLE;
        if (m_full) begin
          e_done = 1;
`ifdef VBDMA_DOUBLE_EN
          m_bank = ~m_bank;
`endif
        end
        m_full = 0;
      end
      default: ;
    endcase
    m_vbp = VB;
  endtask

  // compare DUT with model, then drive the next clock's inputs and advance the model
  task automatic step();
    bit pause_on;
    @(negedge clk);
    chk("busrq_n", busrq_n, !(m_phase == M_REQ || m_phase == M_XFER));
    chk("busy", busy, m_phase != M_IDLE);
    chk("src_cs", src_cs, m_infl);
    if (m_infl) chk("src_addr", src_addr, 64'(m_got));
    chk("dst_we", dst_we, e_we);
    chk("done", done, e_done);
    chk("dst_bank", dst_bank, m_bank);
    if (e_we) begin
      chk("dst_addr", dst_addr[DAW-1:0], 64'(e_addr));
      chk("dst_data", dst_data, e_data);
`ifdef VBDMA_DOUBLE_EN
      chk("dst_addr_bank", dst_addr[DAW], e_wbank);
`endif
    end
    if (dst_we) begin
      f_writes++;
      if (dst_addr[DAW-1:0] == 0) w0 = dst_data;
      if (dst_addr[DAW-1:0] == 191) w191 = dst_data;
      if (dst_addr[DAW-1:0] == 25) w25 = 1;
    end
    if (done) f_dones++;
    if (!busrq_n) f_rq++;
    if (busy) f_busy++;
    if (pcen && src_cs && src_addr == 10) f_a10++;
    if (s_dst_we) s_log.push_back({s_dst_addr[7:0], s_dst_data});
    if (s_done) s_dones++;

    if (m_phase == M_XFER && m_got >= abort_at) vb_drv = 0;
    cen = ($urandom_range(0, 3) != 0);
    pcen = cen;
    VB = vb_drv;
    enable = en_drv;
    pause_on = (m_phase == M_XFER && m_got >= pause_at && paused < pause_len);
    busak_n = !(!busrq_n && rq_cens >= gdelay && !pause_on);
    busak_s = !(!s_busrq_n && s_rq >= 1);
    src_din = src_cs ? ram[src_addr] : 8'($urandom);
    s_din = s_src_cs ? ram[s_src_addr] : 8'($urandom);
    if (cen) begin
      if (pause_on) paused++;
      rq_cens = busrq_n ? 0 : rq_cens + 1;
      s_rq = s_busrq_n ? 0 : s_rq + 1;
      model_cen();
    end else begin
      e_we = 0; e_done = 0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busrq_n"}, busrq_n, 1);
    chk({tag, "_src_cs"}, src_cs, 0);
    chk({tag, "_dst_we"}, dst_we, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_src_addr"}, src_addr, 0);
    chk({tag, "_dst_addr"}, dst_addr, 0);
    chk({tag, "_dst_data"}, dst_data, 0);
    chk({tag, "_dst_bank"}, dst_bank, 0);
  endtask

  task automatic run_frame(input int en, input int gd, input int p_at, input int p_len,
                           input int ab_at, input int rs_at);
    int n, cn, lowc;
    bit started;
    f_writes = 0; f_dones = 0; f_rq = 0; f_busy = 0; f_a10 = 0; w25 = 0; w0 = 0; w191 = 0;
    en_drv = en[0]; gdelay = gd; pause_at = p_at; pause_len = p_len; paused = 0; abort_at = ab_at;
    vb_drv = 1;
    started = 0; n = 0; cn = 0;
    if (en == 0) begin
      while (cn < 60) begin step(); if (pcen) cn++; end
    end else begin
      while (n < 4000) begin
        step();
        if (m_phase != M_IDLE) started = 1;
        if (started && m_phase == M_IDLE) break;
        if (rs_at >= 0 && m_phase == M_XFER && m_got >= rs_at) begin
          #2 rst_n = 0;
          #1 chk_reset_outputs("midreset");
          model_reset();
          vb_drv = 0; VB = 0;
          repeat (2) @(negedge clk);
          rst_n = 1; cen = 0; pcen = 0;
          break;
        end
        n++;
      end
      chk("frame_in_time", n < 4000, 1);
    end
    vb_drv = 0;
    lowc = $urandom_range(8, 20);
    cn = 0;
    while (cn < lowc) begin step(); if (pcen) cn++; end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit bank_before;
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i);
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1; cen = 0;
    model_reset();

    run_frame(1, 2, 9999, 0, 9999, -1);
    chk("f0_writes", f_writes, 192);
    chk("f0_word0", w0, 32'h03020100);
    chk("f0_word191", w191, 32'hFFFEFDFC);
    chk("f0_dones", f_dones, 1);
    chk("small_writes", s_log.size(), 2);
    if (s_log.size() == 2) begin
      chk("small_word0", s_log[0], {8'd0, 32'h03020100});
      chk("small_word1", s_log[1], {8'd1, 32'h00000504});
    end
    chk("small_dones", s_dones, 1);

    run_frame(1, 2, 10, 5, 9999, -1);
    chk("pause_reissue10", f_a10, 2);
    chk("pause_writes", f_writes, 192);
    chk("pause_dones", f_dones, 1);

    bank_before = m_bank;
    run_frame(1, $urandom_range(1, 4), 9999, 0, 101, -1);
    chk("abort_dones", f_dones, 0);
    chk("abort_no_word25", w25, 0);
    chk("abort_writes", f_writes, 25);
    chk("abort_bank", dst_bank, bank_before);

    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    run_frame(1, $urandom_range(1, 4), 9999, 0, 9999, -1);
    chk("after_abort_dones", f_dones, 1);

    run_frame(0, 2, 9999, 0, 9999, -1);
    chk("disabled_busrq", f_rq, 0);
    chk("disabled_busy", f_busy, 0);

    run_frame(1, $urandom_range(1, 4), 9999, 0, 9999, 300);

    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    run_frame(1, $urandom_range(1, 4), $urandom_range(0, LEN - 1), $urandom_range(1, 8),
              ($urandom_range(0, 1) == 1) ? $urandom_range(1, LEN - 1) : 9999, -1);

    run_frame(1, $urandom_range(1, 4), 9999, 0, LEN - 1, -1);
    chk("vbfall_last_dones", f_dones, 1);
    chk("vbfall_last_writes", f_writes, 192);

    run_frame(1, $urandom_range(1, 4), $urandom_range(0, LEN - 1), $urandom_range(1, 8), 9999, -1);
    chk("final_dones", f_dones, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
